// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, status bits,
// TX/RX FSM state encodings and the burst-length clamp.
package uart_mmio_pkg;

    localparam logic [5:0] REG_CTRL = 6'h00;
    localparam logic [5:0] REG_CLR  = 6'h04;
    localparam logic [5:0] REG_RX0  = 6'h10;
    localparam logic [5:0] REG_RX1  = 6'h14;
    localparam logic [5:0] REG_TX0  = 6'h20;
    localparam logic [5:0] REG_TX1  = 6'h24;

    localparam int ST_TX_BUSY  = 8;
    localparam int ST_RX_OVF   = 9;
    localparam int ST_RX_FERR  = 10;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    function automatic logic [3:0] clamp_count(input logic [3:0] n);
        return (n > 4'd8) ? 4'd8 : n;
    endfunction

endpackage

// File: rtl/uart_mmio_rx.sv
// 8N1 receiver: synchronises rx, starts on a falling edge, re-checks the start
// bit at half a period, then samples data and stop bits mid-bit.
module uart_rx_core
    import uart_mmio_pkg::*;
#(
    parameter int UART_PERIOD = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic [1:0] state
);
    localparam int CW = $clog2(UART_PERIOD);
    localparam logic [CW-1:0] BAUD_LAST = CW'(UART_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(UART_PERIOD / 2 - 1);

    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    baud_d  = '0;
                end
            end
            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;
    assign state      = state_q;

endmodule

// File: rtl/uart_mmio_tx.sv
// 8N1 transmitter: sends bytes 0..count-1 of a 64-bit buffer back to back,
// LSB first, each bit held for UART_PERIOD clocks.
module uart_tx_core
    import uart_mmio_pkg::*;
#(
    parameter int UART_PERIOD = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  count,
    input  logic [63:0] tx_buf,
    output logic        tx,
    output logic [1:0]  state
);
    localparam int CW = $clog2(UART_PERIOD);
    localparam logic [CW-1:0] BAUD_LAST = CW'(UART_PERIOD - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [2:0]    last_q, last_d;
    logic          tx_q, tx_d;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        last_d  = last_q;
        case (state_q)
            TX_IDLE: begin
                if (start && count != 4'd0) begin
                    state_d = TX_START;
                    baud_d  = '0;
                    byte_d  = 3'd0;
                    last_d  = count[2:0] - 3'd1;
                end
            end
            TX_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = TX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_q == last_q) begin
                        state_d = TX_IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = TX_START;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
        endcase

        // Line level is registered from the next state so tx never glitches.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_buf[{byte_d, bit_d}];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            last_q  <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
        end
    end

    assign tx    = tx_q;
    assign state = state_q;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: register decode, 8-byte TX and RX buffers, status flags.
// Instantiates one transmitter and one receiver core.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int UART_PERIOD = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  addr,
    input  logic [31:0] data_in,
    input  logic        write_enable,
    output logic [31:0] data_out,
    output logic        tx,
    input  logic        rx
);
    logic [63:0] tx_buf_q, tx_buf_d, rx_buf_q, rx_buf_d;
    logic [3:0]  rx_count_q, rx_count_d;
    logic        ovf_q, ovf_d, ferr_q, ferr_d;
    logic [5:0]  reg_addr;
    logic        clr;
    logic        tx_start, tx_busy;
    logic [3:0]  tx_count;
    logic [1:0]  tx_state, rx_state;
    logic        rx_valid, rx_ferr;
    logic [7:0]  rx_data;

    assign reg_addr = addr & 6'b111100;
    assign tx_busy  = (tx_state != TX_IDLE);

    // Start handshake: tx_start is a one-cycle request that is raised only while
    // tx_busy is low; the core accepts it in that same cycle, so no ack is needed.
    always_comb begin
        tx_buf_d   = tx_buf_q;
        rx_buf_d   = rx_buf_q;
        rx_count_d = rx_count_q;
        ovf_d      = ovf_q;
        ferr_d     = ferr_q;
        tx_start   = 1'b0;
        tx_count   = clamp_count(data_in[3:0]);
        clr        = write_enable && (reg_addr == REG_CLR);

        if (write_enable && !tx_busy) begin
            case (reg_addr)
                REG_CTRL: tx_start = (data_in[3:0] != 4'd0);
                REG_TX0:  tx_buf_d[31:0]  = data_in;
                REG_TX1:  tx_buf_d[63:32] = data_in;
                default:  ;
            endcase
        end

        // A clear beats a byte landing in the same cycle.
        if (clr) begin
            rx_count_d = 4'd0;
            ovf_d      = 1'b0;
            ferr_d     = 1'b0;
        end else begin
            if (rx_valid) begin
                if (rx_count_q == 4'd8) begin
                    ovf_d = 1'b1;
                end else begin
                    rx_buf_d[{rx_count_q[2:0], 3'b000} +: 8] = rx_data;
                    rx_count_d = rx_count_q + 4'd1;
                end
            end
            if (rx_ferr) ferr_d = 1'b1;
        end
    end

    always_comb begin
        data_out = 32'd0;
        case (reg_addr)
            REG_CTRL: data_out = {21'd0, ferr_q, ovf_q, tx_busy, 4'd0, rx_count_q};
            REG_RX0:  data_out = rx_buf_q[31:0];
            REG_RX1:  data_out = rx_buf_q[63:32];
            REG_TX0:  data_out = tx_buf_q[31:0];
            REG_TX1:  data_out = tx_buf_q[63:32];
            default:  data_out = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf_q   <= 64'd0;
            rx_buf_q   <= 64'd0;
            rx_count_q <= 4'd0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tx_buf_q   <= tx_buf_d;
            rx_buf_q   <= rx_buf_d;
            rx_count_q <= rx_count_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
        end
    end

    uart_tx_core #(.UART_PERIOD(UART_PERIOD)) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (tx_start),
        .count  (tx_count),
        .tx_buf (tx_buf_q),
        .tx     (tx),
        .state  (tx_state)
    );

    uart_rx_core #(.UART_PERIOD(UART_PERIOD)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr),
        .state      (rx_state)
    );

endmodule

// File: tb/tb_uart_mmio.sv
// Two cross-connected UART peripherals; B's receive line can be overridden to
// inject malformed frames and glitches.
module tb_uart_mmio;
    import uart_mmio_pkg::*;

    localparam int P = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [5:0]  addr [2];
    logic [31:0] din  [2];
    logic        we   [2];
    logic [31:0] dout [2];
    logic        txl  [2];
    logic        rxl  [2];
    logic        force_en, force_val;

    assign rxl[0] = txl[1];
    assign rxl[1] = force_en ? force_val : txl[0];

    uart_mmio #(.UART_PERIOD(P)) u_a (
        .clk(clk), .rst_n(rst_n), .addr(addr[0]), .data_in(din[0]),
        .write_enable(we[0]), .data_out(dout[0]), .tx(txl[0]), .rx(rxl[0]));
    uart_mmio #(.UART_PERIOD(P)) u_b (
        .clk(clk), .rst_n(rst_n), .addr(addr[1]), .data_in(din[1]),
        .write_enable(we[1]), .data_out(dout[1]), .tx(txl[1]), .rx(rxl[1]));

    int n_cmp = 0;
    int n_fail = 0;

    // ---------------- reference model (per instance receive side) ----------------
    logic [7:0] m_rx [2][8];
    int         m_cnt [2];
    logic       m_ovf [2];
    logic       m_ferr [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) m_rx[i][k] = 8'd0;
            m_cnt[i] = 0; m_ovf[i] = 1'b0; m_ferr[i] = 1'b0;
        end
    endtask

    task automatic model_clear(input int i);
        m_cnt[i] = 0; m_ovf[i] = 1'b0; m_ferr[i] = 1'b0;
    endtask

    task automatic model_byte(input int i, input logic [7:0] b);
        if (m_cnt[i] == 8) m_ovf[i] = 1'b1;
        else begin
            m_rx[i][m_cnt[i]] = b;
            m_cnt[i]++;
        end
    endtask

    function automatic logic [31:0] exp_status(input int i);
        logic [31:0] s;
        s = 32'(m_cnt[i]);
        if (m_ovf[i])  s = s + 32'h200;
        if (m_ferr[i]) s = s + 32'h400;
        return s;
    endfunction

    function automatic logic [31:0] exp_rx_word(input int i, input int w);
        return {m_rx[i][4*w+3], m_rx[i][4*w+2], m_rx[i][4*w+1], m_rx[i][4*w]};
    endfunction

    function automatic logic [5:0] rx_reg(input int r);
        return (r == 0) ? REG_CTRL : (r == 1) ? REG_RX0 : REG_RX1;
    endfunction

    function automatic logic [31:0] rx_exp(input int i, input int r);
        return (r == 0) ? exp_status(i) : exp_rx_word(i, r - 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic write_reg(input int i, input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        addr[i] = a; din[i] = d; we[i] = 1'b1;
        @(negedge clk);
        we[i] = 1'b0;
    endtask

    task automatic read_reg(input int i, input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        addr[i] = a;
        #1 d = dout[i];
    endtask

    task automatic wait_idle(input int i, input int budget, input string name);
        logic [31:0] s;
        int k;
        for (k = 0; k < budget; k++) begin
            read_reg(i, REG_CTRL, s);
            if (!s[ST_TX_BUSY]) break;
        end
        n_cmp++;
        if (k == budget) begin
            n_fail++;
            $display("FAIL %s_idle: tx_busy still 1 after %0d cycles, required 0", name, budget);
        end
    endtask

    task automatic send_burst(input int src, input logic [63:0] bytes, input logic [3:0] nf,
                              input string name);
        int n;
        write_reg(src, REG_TX0, bytes[31:0]);
        write_reg(src, REG_TX1, bytes[63:32]);
        write_reg(src, REG_CTRL, {28'd0, nf});
        wait_idle(src, 60 * 8 + 20, name);
        repeat (10) @(negedge clk);
        n = (nf > 4'd8) ? 8 : int'(nf);
        for (int k = 0; k < n; k++) model_byte(1 - src, bytes[8*k +: 8]);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            force_val = f[k];
            repeat (P - 1) @(negedge clk);
        end
        @(negedge clk);
        force_val = 1'b1;
        repeat (3 * P) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] got;
        logic [5:0]  regs [8];
        regs = '{REG_CTRL, REG_CLR, REG_RX0, REG_RX1, REG_TX0, REG_TX1, 6'h08, 6'h3c};
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 8; r++) begin
                read_reg(i, regs[r], got);
                n_cmp++;
                if (got !== 32'd0) begin
                    n_fail++;
                    $display("FAIL reset_reg inst%0d 0x%02h: got 0x%08h, expected 0x00000000", i, regs[r], got);
                end
            end
            n_cmp++;
            if (txl[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_tx inst%0d: got %b, expected 1", i, txl[i]);
            end
        end
    endtask

    task automatic test_loopback();
        logic [31:0] got;
        write_reg(0, REG_TX0, 32'h00CCBBAA);
        write_reg(0, REG_TX1, 32'hABABABAB);
        write_reg(0, REG_CTRL, 32'd5);
        repeat (300) @(negedge clk);
        model_byte(1, 8'hAA); model_byte(1, 8'hBB); model_byte(1, 8'hCC);
        model_byte(1, 8'h00); model_byte(1, 8'hAB);
        for (int r = 0; r < 3; r++) begin
            read_reg(1, rx_reg(r), got);
            n_cmp++;
            if (got !== rx_exp(1, r)) begin
                n_fail++;
                $display("FAIL loopback reg 0x%02h: got 0x%08h, expected 0x%08h", rx_reg(r), got, rx_exp(1, r));
            end
        end
        read_reg(0, REG_TX0, got);
        n_cmp++;
        if (got !== 32'h00CCBBAA) begin
            n_fail++;
            $display("FAIL loopback_txbuf: got 0x%08h, expected 0x00CCBBAA", got);
        end
        write_reg(1, REG_CLR, $urandom);
        model_clear(1);
        for (int r = 0; r < 3; r++) begin
            read_reg(1, rx_reg(r), got);
            n_cmp++;
            if (got !== rx_exp(1, r)) begin
                n_fail++;
                $display("FAIL clear reg 0x%02h: got 0x%08h, expected 0x%08h", rx_reg(r), got, rx_exp(1, r));
            end
        end
    endtask

    task automatic test_random_bursts();
        logic [31:0] got;
        logic [63:0] bytes;
        logic [3:0]  nf;
        int          src, dst;
        for (int it = 0; it < 6; it++) begin
            src = it % 2;
            dst = 1 - src;
            if ($urandom_range(0, 1) == 1) begin
                write_reg(dst, REG_CLR, 32'd0);
                model_clear(dst);
            end
            bytes = {$urandom, $urandom};
            nf = 4'($urandom_range(1, 15));
            send_burst(src, bytes, nf, "random");
            for (int r = 0; r < 3; r++) begin
                read_reg(dst, rx_reg(r), got);
                n_cmp++;
                if (got !== rx_exp(dst, r)) begin
                    n_fail++;
                    $display("FAIL random it%0d n=%0d inst%0d reg 0x%02h: got 0x%08h, expected 0x%08h",
                             it, nf, dst, rx_reg(r), got, rx_exp(dst, r));
                end
            end
        end
    endtask

    task automatic test_bit_timing();
        logic [9:0]  frame;
        logic        exp_tx, exp_busy;
        logic [31:0] got;
        write_reg(1, REG_CLR, 32'd0);
        model_clear(1);
        write_reg(0, REG_TX0, 32'h00000055);
        write_reg(0, REG_CTRL, 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int c = 0; c < 52; c++) begin
            if (c > 0) @(negedge clk);
            addr[0] = REG_CTRL;
            #1 got = dout[0];
            exp_tx   = (c >= 10 * P) ? 1'b1 : frame[c / P];
            exp_busy = (c < 10 * P);
            n_cmp++;
            if (txl[0] !== exp_tx || got[ST_TX_BUSY] !== exp_busy) begin
                n_fail++;
                $display("FAIL bit_timing cycle %0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         c, txl[0], got[ST_TX_BUSY], exp_tx, exp_busy);
            end
        end
        repeat (10) @(negedge clk);
        model_byte(1, 8'h55);
        for (int r = 0; r < 2; r++) begin
            read_reg(1, rx_reg(r), got);
            n_cmp++;
            if (got !== rx_exp(1, r)) begin
                n_fail++;
                $display("FAIL bit_timing_rx reg 0x%02h: got 0x%08h, expected 0x%08h", rx_reg(r), got, rx_exp(1, r));
            end
        end
    endtask

    task automatic test_busy_lockout();
        logic [31:0] w0, got;
        write_reg(1, REG_CLR, 32'd0);
        model_clear(1);
        w0 = $urandom;
        write_reg(0, REG_TX0, w0);
        write_reg(0, REG_CTRL, 32'd2);
        repeat (20) @(negedge clk);
        write_reg(0, REG_CTRL, 32'd1);
        write_reg(0, REG_TX0, ~w0);
        read_reg(0, REG_TX0, got);
        n_cmp++;
        if (got !== w0) begin
            n_fail++;
            $display("FAIL lockout_txbuf: got 0x%08h, expected 0x%08h", got, w0);
        end
        read_reg(0, REG_CTRL, got);
        n_cmp++;
        if (got !== 32'h100) begin
            n_fail++;
            $display("FAIL lockout_busy: got 0x%08h, expected 0x00000100", got);
        end
        wait_idle(0, 200, "lockout");
        repeat (60) @(negedge clk);
        model_byte(1, w0[7:0]);
        model_byte(1, w0[15:8]);
        for (int r = 0; r < 2; r++) begin
            read_reg(1, rx_reg(r), got);
            n_cmp++;
            if (got !== rx_exp(1, r)) begin
                n_fail++;
                $display("FAIL lockout_rx reg 0x%02h: got 0x%08h, expected 0x%08h", rx_reg(r), got, rx_exp(1, r));
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got;
        write_reg(1, REG_CLR, 32'd0);
        model_clear(1);
        send_burst(0, {$urandom, $urandom}, 4'd8, "ovf8");
        send_burst(0, {32'd0, $urandom}, 4'd1, "ovf1");
        for (int r = 0; r < 3; r++) begin
            read_reg(1, rx_reg(r), got);
            n_cmp++;
            if (got !== rx_exp(1, r)) begin
                n_fail++;
                $display("FAIL overflow reg 0x%02h: got 0x%08h, expected 0x%08h", rx_reg(r), got, rx_exp(1, r));
            end
        end
        write_reg(1, REG_CLR, 32'hFFFFFFFF);
        model_clear(1);
        read_reg(1, REG_CTRL, got);
        n_cmp++;
        if (got !== exp_status(1)) begin
            n_fail++;
            $display("FAIL overflow_clear: got 0x%08h, expected 0x%08h", got, exp_status(1));
        end
    endtask

    task automatic test_framing();
        logic [31:0] got;
        logic [7:0]  b;
        write_reg(1, REG_CLR, 32'd0);
        model_clear(1);
        force_val = 1'b1;
        force_en  = 1'b1;
        repeat (10) @(negedge clk);
        b = 8'($urandom);
        drive_frame(b, 1'b1);
        model_byte(1, b);
        drive_frame(8'($urandom), 1'b0);
        m_ferr[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            read_reg(1, rx_reg(r), got);
            n_cmp++;
            if (got !== rx_exp(1, r)) begin
                n_fail++;
                $display("FAIL framing reg 0x%02h: got 0x%08h, expected 0x%08h", rx_reg(r), got, rx_exp(1, r));
            end
        end
        write_reg(1, REG_CLR, 32'd0);
        model_clear(1);
        @(negedge clk);
        force_val = 1'b0;
        repeat (2) @(negedge clk);
        force_val = 1'b1;
        repeat (40) @(negedge clk);
        read_reg(1, REG_CTRL, got);
        n_cmp++;
        if (got !== exp_status(1)) begin
            n_fail++;
            $display("FAIL glitch: got 0x%08h, expected 0x%08h", got, exp_status(1));
        end
        force_en = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] got;
        logic [63:0] bytes;
        write_reg(0, REG_TX0, $urandom);
        write_reg(0, REG_CTRL, 32'd3);
        repeat (5 * 10 + 1) @(negedge clk);
        n_cmp++;
        if (txl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pre: tx=%b in second start bit, expected 0", txl[0]);
        end
        #2 rst_n = 1'b0;
        addr[0] = REG_CTRL;
        addr[1] = REG_CTRL;
        #1;
        model_reset();
        n_cmp++;
        if (txl[0] !== 1'b1 || dout[0] !== 32'd0 || dout[1] !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: tx=%b statA=0x%08h statB=0x%08h, expected 1/0/0", txl[0], dout[0], dout[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_reg(0, REG_TX0, got);
        n_cmp++;
        if (got !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_txbuf: got 0x%08h, expected 0x00000000", got);
        end
        bytes = {$urandom, $urandom};
        send_burst(0, bytes, 4'd2, "post_reset");
        for (int r = 0; r < 3; r++) begin
            read_reg(1, rx_reg(r), got);
            n_cmp++;
            if (got !== rx_exp(1, r)) begin
                n_fail++;
                $display("FAIL post_reset reg 0x%02h: got 0x%08h, expected 0x%08h", rx_reg(r), got, rx_exp(1, r));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        force_en = 1'b0;
        force_val = 1'b1;
        for (int i = 0; i < 2; i++) begin
            addr[i] = 6'd0; din[i] = 32'd0; we[i] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_loopback();
        test_bit_timing();
        test_busy_lockout();
        test_overflow();
        test_framing();
        test_random_bursts();
        test_reset_mid_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
